// File: rtl/par_i_ser_o_if.sv
// Bundle for the parallel-in/serial-out transmitter: the request side drives the word
// and the start strobe; the transmitter drives the serial line and the status flags.
interface par_i_ser_o_if #(
  parameter int DATA_W = 8
);
  // Handshake: i_start is a level request, taken on any rising edge where o_busy is low.
  // i_data is sampled on that edge only. o_busy stays high from the accepting edge until
  // the o_done cycle; o_done pulses for one cycle with o_busy low, so a request held high
  // in that cycle starts the next frame with no extra gap.
  logic [DATA_W-1:0] i_data;
  logic              i_start;
  logic              o_serial;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_data,
    output i_start,
    input  o_serial,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_start,
    output o_serial,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/par_i_ser_o.sv
// Parallel-in, serial-out frame transmitter: start(1), data MSB first, stop(0).
// Optional even-parity bit before the stop bit when PAR_I_SER_O_PARITY_EN is defined.
module par_i_ser_o #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  par_i_ser_o_if.slave      bus,
  output logic [2:0]        state_dbg
);

  localparam int             IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]     CNT_MAX = 8'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PAR_I_SER_O_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   shifted;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef PAR_I_SER_O_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign shifted = shreg_q << 1;

  // Outputs are registered, so each branch loads the line value of the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef PAR_I_SER_O_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d  = START;
          shreg_d  = bus.i_data;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = 1'b1;
          busy_d   = 1'b1;
`ifdef PAR_I_SER_O_PARITY_EN
          parity_d = ^bus.i_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          cnt_d    = '0;
          serial_d = shreg_q[DATA_W-1];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef PAR_I_SER_O_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = 1'b0;
`endif
          end else begin
            idx_d    = idx_q + IDX_ONE;
            shreg_d  = shifted;
            serial_d = shifted[DATA_W-1];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef PAR_I_SER_O_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          cnt_d    = '0;
          serial_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PAR_I_SER_O_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PAR_I_SER_O_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.o_serial = serial_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/par_i_ser_o.md
PAR_I_SER_O -- requirements
Module: par_i_ser_o

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..255.
REQ-002 The block SHALL have parameter DATA_W, default 8, width of the parallel word.
REQ-003 The block SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_data  input  DATA_W  parallel word to transmit, sampled only on an accepted start.
REQ-006 The block SHALL have port i_start  input  1  transmit request, level-sampled each cycle.
REQ-007 The block SHALL have port o_serial  output  1  registered serial line, idle low.
REQ-008 The block SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-009 The block SHALL have port o_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 Frame format SHALL be: start bit (1), DATA_W data bits MSB first, optional parity bit (see Configuration), stop bit (0); each bit held exactly CLKS_PER_BIT cycles.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (only when compiled in), STOP.
REQ-012 In IDLE with i_start=1 at edge t, the block SHALL latch i_data into a shift register, enter START, and drive o_serial=1 and o_busy=1 from edge t onward (first START cycle is t+1).
REQ-013 A bit counter (0..CLKS_PER_BIT-1) SHALL advance the FSM when it reaches CLKS_PER_BIT-1; START->DATA, DATA->DATA until DATA_W bits sent, then ->PARITY or ->STOP, STOP->IDLE.
REQ-014 A data-bit index SHALL count 0..DATA_W-1; it SHALL NOT wrap mid-frame.
REQ-015 On the STOP->IDLE transition the block SHALL assert o_done=1 and o_busy=0 for exactly one cycle, with o_serial=0.
REQ-016 i_start asserted while o_busy=1 SHALL be ignored; i_data changes during a frame SHALL NOT affect the frame in flight.
REQ-017 i_start asserted in the o_done cycle SHALL be accepted (back-to-back frames, no idle gap beyond that cycle).
REQ-018 Total latency from accepted i_start edge to o_done edge SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is compiled in.
REQ-019 CLKS_PER_BIT=1 SHALL produce one bit per cycle with identical frame ordering.

Reset
REQ-020 i_reset=1 SHALL force state IDLE, o_serial=0, o_busy=0, o_done=0, and clear counters and shift register on the next edge.
REQ-021 Reset asserted mid-frame SHALL abort the frame without an o_done pulse; reset has priority over i_start.

Configuration
REQ-022 Macro PAR_I_SER_O_PARITY_EN defined: a PARITY state SHALL transmit an even-parity bit (XOR of the DATA_W data bits) between the last data bit and the stop bit.
REQ-023 Macro PAR_I_SER_O_PARITY_EN undefined: no PARITY state or logic SHALL exist; DATA goes directly to STOP.

Verification
REQ-024 CLKS_PER_BIT=4, no parity, i_start one cycle with i_data=8'hA5 -> o_serial 1,1,0,1,0,0,1,0,1,0 each 4 cycles; o_done pulses exactly 40 cycles after the accepting edge.
REQ-025 During that frame, i_start=1 with i_data=8'hFF at cycle 10 -> ignored; the serial stream is unchanged and a single o_done is produced.
REQ-026 i_start held high continuously with i_data=8'h3C then 8'hC3 -> two frames back-to-back, the second start bit beginning the cycle after the first o_done.
REQ-027 i_reset=1 at cycle 20 of a frame -> next cycle o_serial=0, o_busy=0; no o_done; a new i_start is accepted after reset deasserts.
REQ-028 PAR_I_SER_O_PARITY_EN defined, i_data=8'h07 -> parity bit 1 (i_data=8'hA5 -> parity bit 0); o_done 44 cycles after the accepting edge.
REQ-029 CLKS_PER_BIT=1, i_data=8'h80 -> o_serial 1,1,0,0,0,0,0,0,0,0 on consecutive cycles; o_done 10 cycles after the accepting edge.
